// File: rtl/dmem_lsu.sv
// Single-port data memory with RV32 load/store formatting, fault detection and
// a configurable load latency; one request in flight at a time.
module dmem_lsu #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DEPTH         = 1024,
  parameter int READ_LATENCY  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [31:0]              req_wdata,
  output logic                     rsp_valid,
  output logic [31:0]              rsp_rdata,
  output logic                     rsp_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    RESP      = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;

  logic [3:0][7:0] mem_q [DEPTH];

  logic [ADDRESS_WIDTH-3:0] word_idx;
  logic [IDX_W-1:0]         mem_idx;
  logic [1:0]               lane;
  logic                     in_range;
  logic                     bad_op;
  logic                     fault;
  logic                     accept;
  logic                     wr_en;
  logic [3:0]               wr_be;
  logic [31:0]              wr_data;
  logic [31:0]              rd_word;
  logic [31:0]              rd_shift;
  logic [31:0]              load_data;

  assign word_idx = req_addr[ADDRESS_WIDTH-1:2];
  assign mem_idx  = word_idx[IDX_W-1:0];
  assign lane     = req_addr[1:0];
  assign in_range = (64'(word_idx) < 64'(DEPTH));
  assign accept   = req_valid && req_ready;
  assign wr_en    = accept && req_we && !fault;

  // Width/alignment legality; BU/HU have no store counterpart.
  always_comb begin
    bad_op = 1'b0;
    case (req_funct3)
      3'b000:  bad_op = 1'b0;
      3'b001:  bad_op = lane[0];
      3'b010:  bad_op = |lane;
      3'b100:  bad_op = req_we;
      3'b101:  bad_op = req_we | lane[0];
      default: bad_op = 1'b1;
    endcase
    fault = bad_op || !in_range;
  end

  always_comb begin
    wr_be   = 4'b1111;
    wr_data = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        wr_be   = 4'b0001 << lane;
        wr_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        wr_be   = lane[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{req_wdata[15:0]}};
      end
      default: begin
        wr_be   = 4'b1111;
        wr_data = req_wdata;
      end
    endcase
  end

  always_comb begin
    rd_word   = mem_q[mem_idx];
    rd_shift  = rd_word >> {lane, 3'b000};
    load_data = 32'd0;
    case (req_funct3)
      3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b100:  load_data = {24'd0, rd_shift[7:0]};
      3'b001:  load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b101:  load_data = {16'd0, rd_shift[15:0]};
      3'b010:  load_data = rd_word;
      default: load_data = 32'd0;
    endcase
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem_q[mem_idx][i] <= wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      data_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Load data is captured at acceptance; nothing can write while it waits.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (accept) begin
          err_d  = fault;
          data_d = (fault || req_we) ? 32'd0 : load_data;
          if (!fault && !req_we && (READ_LATENCY > 1)) begin
            state_d = LOAD_WAIT;
            cnt_d   = 2'(READ_LATENCY - 2);
          end else begin
            state_d = RESP;
          end
        end
      end
      LOAD_WAIT: begin
        if (cnt_q == 2'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 2'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = !rst && ((state_q == IDLE) || (state_q == RESP));
    rsp_valid = (state_q == RESP);
    rsp_rdata = rsp_valid ? data_q : 32'd0;
    rsp_err   = rsp_valid && err_q;
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: byte-array reference model, directed corner
// cases, then randomized traffic including requests offered while not ready.
module tb_dmem_lsu;
  localparam int AW    = 12;
  localparam int DEPTH = 64;
  localparam int RL    = 3;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;

  dmem_lsu #(.ADDRESS_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(RL)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] ref_mem [DEPTH*4];
  int         tests = 0;
  int         fails = 0;

  // Reference: memory as a flat little-endian byte array.
  function automatic void model(input logic we, input logic [2:0] f3,
                                input logic [AW-1:0] addr, input logic [31:0] wd,
                                output logic [31:0] rd, output logic err,
                                output int lat);
    int a;
    int size;
    logic [31:0] v;
    a = int'(addr);
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      default:    size = 4;
    endcase
    err = 1'b0;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) err = 1'b1;
    if (we && (f3 == 3'd4 || f3 == 3'd5)) err = 1'b1;
    if ((a % size) != 0) err = 1'b1;
    if ((a / 4) >= DEPTH) err = 1'b1;
    rd  = 32'd0;
    lat = 1;
    if (!err && we) begin
      for (int i = 0; i < size; i++) ref_mem[a+i] = wd[8*i +: 8];
    end else if (!err) begin
      v = 32'd0;
      for (int i = 0; i < size; i++) v = v | (32'(ref_mem[a+i]) << (8*i));
      if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
      if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
      rd  = v;
      lat = RL;
    end
  endfunction

  task automatic chk_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] f3,
                       input logic [AW-1:0] addr, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
  endtask

  task automatic record(input logic we, input logic [2:0] f3,
                        input logic [AW-1:0] addr, input logic [31:0] wd,
                        input bit fixed, input logic [31:0] fd, input logic fe);
    logic [31:0] rd;
    logic        err;
    int          lat;
    exp_t        e;
    model(we, f3, addr, wd, rd, err, lat);
    e.cyc  = cyc + lat;
    e.data = fixed ? fd : rd;
    e.err  = fixed ? fe : err;
    sbq.push_back(e);
  endtask

  // Presents a request and holds it until accepted (bounded).
  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [AW-1:0] addr, input logic [31:0] wd,
                       input bit fixed = 1'b0, input logic [31:0] fd = 32'd0,
                       input logic fe = 1'b0);
    int n = 0;
    @(negedge clk);
    drive(we, f3, addr, wd);
    while (!req_ready) begin
      n++;
      if (n > 50) begin
        tests++;
        fails++;
        $display("FAIL issue_timeout: req_ready stayed %b, expected 1", req_ready);
        return;
      end
      @(negedge clk);
    end
    record(we, f3, addr, wd, fixed, fd, fe);
  endtask

  // Offers a request for a single cycle; ignored if the block is busy.
  task automatic present_once(input logic we, input logic [2:0] f3,
                              input logic [AW-1:0] addr, input logic [31:0] wd);
    @(negedge clk);
    drive(we, f3, addr, wd);
    if (req_ready) record(we, f3, addr, wd, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    tests++;
    if (rsp_valid) begin
      if (sbq.size() == 0 || sbq[0].cyc != cyc) begin
        fails++;
        $display("FAIL rsp_unexpected: got valid data=%h err=%b, expected no response (cycle %0d)",
                 rsp_rdata, rsp_err, cyc);
      end else begin
        e = sbq.pop_front();
        if (rsp_rdata !== e.data || rsp_err !== e.err) begin
          fails++;
          $display("FAIL rsp_data: got data=%h err=%b, expected data=%h err=%b (cycle %0d)",
                   rsp_rdata, rsp_err, e.data, e.err, cyc);
        end
      end
    end else begin
      if (rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
        fails++;
        $display("FAIL idle_outputs: got data=%h err=%b, expected 0/0 (cycle %0d)",
                 rsp_rdata, rsp_err, cyc);
      end
      if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        fails++;
        $display("FAIL rsp_missing: got no valid, expected data=%h err=%b at cycle %0d",
                 sbq[0].data, sbq[0].err, sbq[0].cyc);
        void'(sbq.pop_front());
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    logic          r_we;
    logic [2:0]    r_f3;
    logic [AW-1:0] r_addr;
    int            sel;

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = '0;
    req_wdata  = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    chk_val("reset_ready", 32'(req_ready), 32'd0);
    chk_val("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk_val("post_reset_ready", 32'(req_ready), 32'd1);

    for (int w = 0; w < DEPTH; w++) issue(1'b1, 3'd2, AW'(w*4), $urandom);

    // Load width/extension cases
    issue(1'b1, 3'd2, 12'h010, 32'hDEADBEEF);
    issue(1'b0, 3'd0, 12'h013, 32'd0, 1'b1, 32'hFFFFFFDE, 1'b0);
    issue(1'b0, 3'd4, 12'h013, 32'd0, 1'b1, 32'h000000DE, 1'b0);
    issue(1'b0, 3'd1, 12'h012, 32'd0, 1'b1, 32'hFFFFDEAD, 1'b0);
    issue(1'b0, 3'd5, 12'h012, 32'd0, 1'b1, 32'h0000DEAD, 1'b0);

    // Misaligned store must not write
    issue(1'b1, 3'd2, 12'h020, 32'hCAFEF00D);
    issue(1'b1, 3'd1, 12'h021, 32'h00001234, 1'b1, 32'd0, 1'b1);
    issue(1'b0, 3'd2, 12'h020, 32'd0, 1'b1, 32'hCAFEF00D, 1'b0);

    issue(1'b0, 3'd2, AW'(4*DEPTH), 32'd0, 1'b1, 32'd0, 1'b1);
    issue(1'b0, 3'd3, 12'h000, 32'd0, 1'b1, 32'd0, 1'b1);

    // Store then immediate load of the same word
    issue(1'b1, 3'd2, 12'h040, 32'h11223344);
    issue(1'b1, 3'd0, 12'h040, 32'h000000AA);
    issue(1'b0, 3'd2, 12'h040, 32'd0, 1'b1, 32'h112233AA, 1'b0);

    // Ready profile around a multi-cycle load
    idle(2);
    issue(1'b0, 3'd2, 12'h044, 32'd0);
    idle(1);
    #1 chk_val("lw_ready_t1", 32'(req_ready), 32'd0);
    idle(1);
    #1 chk_val("lw_ready_t2", 32'(req_ready), 32'd0);
    idle(1);
    #1 chk_val("lw_ready_t3", 32'(req_ready), 32'd1);
    chk_val("lw_valid_t3", 32'(rsp_valid), 32'd1);

    // Store throughput
    issue(1'b1, 3'd2, 12'h080, $urandom);
    c0 = cyc;
    for (int i = 1; i < 8; i++) issue(1'b1, 3'd2, AW'(12'h080 + 4*i), $urandom);
    chk_val("store_throughput", 32'(cyc - c0), 32'd7);

    // Reset during a pending load drops its response
    idle(1);
    issue(1'b0, 3'd2, 12'h048, 32'd0);
    idle(1);
    @(negedge clk);
    rst = 1'b1;
    sbq.delete();
    #1 chk_val("rst_ready_low", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk_val("ready_after_rst", 32'(req_ready), 32'd1);
    idle(7);

    // Request coinciding with reset is ignored
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 3'd2, 12'h048, 32'h55555555);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b0;
    idle(1);
    issue(1'b0, 3'd2, 12'h048, 32'd0);
    idle(1);

    repeat (800) begin
      if ($urandom_range(3) == 0) begin
        idle(1);
      end else begin
        r_we = 1'($urandom_range(1));
        sel  = $urandom_range(15);
        case (sel)
          0, 1, 2:    r_f3 = 3'd0;
          3, 4:       r_f3 = 3'd1;
          5, 6, 7:    r_f3 = 3'd2;
          8, 9:       r_f3 = 3'd4;
          10, 11:     r_f3 = 3'd5;
          12:         r_f3 = 3'd3;
          13:         r_f3 = 3'd6;
          default:    r_f3 = 3'd7;
        endcase
        sel = $urandom_range(9);
        if (sel == 0)      r_addr = AW'($urandom_range(4095));
        else if (sel < 5)  r_addr = AW'($urandom_range(31));
        else               r_addr = AW'($urandom_range(DEPTH*4 - 1));
        present_once(r_we, r_f3, r_addr, $urandom);
      end
    end

    idle(RL + 3);
    chk_val("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
